// File: rtl/ts_packet_aligner.sv
// ts_packet_aligner
//   Locks onto the 0x47 sync byte of an MPEG transport stream and
//   re-emits the byte stream aligned to packet boundaries.
//
//   HUNT   : wait for a sync candidate.
//   VERIFY : require LOCK_COUNT candidates spaced PKT_LEN valid bytes apart.
//   LOCKED : forward every valid byte one cycle later and regenerate the
//            packet-start flag. Flywheel through up to UNLOCK_COUNT-1
//            consecutive missing syncs.
//
// Ports
//   CLOCK        in   TS byte clock, rising edge
//   RESET        in   asynchronous active-high reset
//   TS_VALID_IN  in   input byte valid
//   TS_SYNC_IN   in   input packet-start flag (ignored when USE_SYNC_PIN=0)
//   TS_DATA_IN   in   input byte [7:0]
//   TS_VALID_OUT out  aligned output byte valid
//   TS_SYNC_OUT  out  regenerated packet-start flag
//   TS_DATA_OUT  out  aligned output byte [7:0], holds when not valid
//   LOCKED       out  high while in LOCKED
//   PKT_COUNT    out  packets emitted [15:0], saturating
//   ERR_COUNT    out  sync misses while locked [15:0], saturating
module ts_packet_aligner #(
  parameter int unsigned PKT_LEN      = 188,
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned UNLOCK_COUNT = 3,
  parameter int unsigned USE_SYNC_PIN = 1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        TS_VALID_IN,
  input  logic        TS_SYNC_IN,
  input  logic [7:0]  TS_DATA_IN,
  output logic        TS_VALID_OUT,
  output logic        TS_SYNC_OUT,
  output logic [7:0]  TS_DATA_OUT,
  output logic        LOCKED,
  output logic [15:0] PKT_COUNT,
  output logic [15:0] ERR_COUNT
);

  localparam logic [7:0] LAST_POS = 8'(PKT_LEN - 1);
  localparam logic [2:0] LOCK_N   = 3'(LOCK_COUNT);
  localparam logic [2:0] UNLOCK_N = 3'(UNLOCK_COUNT);
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    S_HUNT,
    S_VERIFY,
    S_LOCKED
  } state_t;

  state_t      state, state_n;
  logic [7:0]  pos, pos_n;
  logic [2:0]  good_cnt, good_cnt_n;
  logic [2:0]  miss_cnt, miss_cnt_n;

  logic        candidate;
  logic        at_zero;
  logic [7:0]  pos_inc;
  logic        emit;
  logic        emit_sync;
  logic        err_inc;

  always_comb begin
    candidate = TS_VALID_IN && (TS_DATA_IN == SYNC_BYTE) &&
                ((USE_SYNC_PIN == 0) || TS_SYNC_IN);
    at_zero   = (pos == '0);
    pos_inc   = (pos == LAST_POS) ? '0 : pos + 8'd1;
  end

  // Next-state and emit decisions. Everything is gated by TS_VALID_IN so
  // that invalid cycles leave state and counters untouched.
  always_comb begin
    state_n    = state;
    pos_n      = pos;
    good_cnt_n = good_cnt;
    miss_cnt_n = miss_cnt;
    emit       = 1'b0;
    emit_sync  = 1'b0;
    err_inc    = 1'b0;

    if (TS_VALID_IN) begin
      unique case (state)
        S_HUNT: begin
          if (candidate) begin
            // The candidate itself occupies position 0.
            pos_n      = 8'd1;
            good_cnt_n = 3'd1;
            if (LOCK_COUNT == 1) begin
              state_n    = S_LOCKED;
              miss_cnt_n = '0;
              emit       = 1'b1;
              emit_sync  = 1'b1;
            end else begin
              state_n = S_VERIFY;
            end
          end
        end

        S_VERIFY: begin
          if (at_zero) begin
            if (candidate) begin
              pos_n = pos_inc;
              if (good_cnt + 3'd1 >= LOCK_N) begin
                state_n    = S_LOCKED;
                good_cnt_n = '0;
                miss_cnt_n = '0;
                emit       = 1'b1;
                emit_sync  = 1'b1;
              end else begin
                good_cnt_n = good_cnt + 3'd1;
              end
            end else begin
              // The failing byte is consumed here; hunting resumes with
              // the following byte.
              state_n    = S_HUNT;
              pos_n      = '0;
              good_cnt_n = '0;
            end
          end else begin
            pos_n = pos_inc;
          end
        end

        S_LOCKED: begin
          if (at_zero) begin
            if (candidate) begin
              miss_cnt_n = '0;
              pos_n      = pos_inc;
              emit       = 1'b1;
              emit_sync  = 1'b1;
            end else begin
              err_inc = 1'b1;
              if (miss_cnt + 3'd1 >= UNLOCK_N) begin
                state_n    = S_HUNT;
                pos_n      = '0;
                miss_cnt_n = '0;
                good_cnt_n = '0;
              end else begin
                // Flywheel: trust the position counter for this packet.
                miss_cnt_n = miss_cnt + 3'd1;
                pos_n      = pos_inc;
                emit       = 1'b1;
                emit_sync  = 1'b1;
              end
            end
          end else begin
            pos_n = pos_inc;
            emit  = 1'b1;
          end
        end

        default: begin
          state_n    = S_HUNT;
          pos_n      = '0;
          good_cnt_n = '0;
          miss_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state    <= S_HUNT;
      pos      <= '0;
      good_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      good_cnt <= good_cnt_n;
      miss_cnt <= miss_cnt_n;
    end
  end

  // Output stage: LOCKED is taken from the next state so it rises together
  // with the first emitted byte.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      TS_VALID_OUT <= 1'b0;
      TS_SYNC_OUT  <= 1'b0;
      TS_DATA_OUT  <= '0;
      LOCKED       <= 1'b0;
      PKT_COUNT    <= '0;
      ERR_COUNT    <= '0;
    end else begin
      TS_VALID_OUT <= emit;
      TS_SYNC_OUT  <= emit_sync;
      LOCKED       <= (state_n == S_LOCKED);
      if (emit) begin
        TS_DATA_OUT <= TS_DATA_IN;
      end
      if (emit_sync && (PKT_COUNT != '1)) begin
        PKT_COUNT <= PKT_COUNT + 16'd1;
      end
      if (err_inc && (ERR_COUNT != '1)) begin
        ERR_COUNT <= ERR_COUNT + 16'd1;
      end
    end
  end

endmodule
